// File: rtl/io_arbiter_pkg.sv
// Shared definitions for the round-robin I/O arbiter: FSM encoding,
// default word width and the width of the requester index.
package io_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_XFER = 1'b1;

  localparam int DATA_W_DEF = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sized for the largest legal requester count so out_src never changes width.
  localparam int SRC_W = idx_w(8);

endpackage

// File: rtl/io_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set request after ptr wins,
// found by rotating a doubled request vector and priority-encoding it.
module rr_pick
  import io_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [SRC_W-1:0] pick_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int                 start;
  int                 off;

  always_comb begin
    start = (int'(ptr) >= N_REQ - 1) ? 0 : int'(ptr) + 1;
    dbl   = {req, req} >> start;
    rot   = dbl[N_REQ-1:0];
    any   = |req;
    off   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    pick_idx = SRC_W'((start + off) % N_REQ);
    pick     = any ? (N_REQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel among N_REQ
// burst requesters, with forced release after MAX_BEATS words.
module io_arbiter
  import io_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BEATS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SRC_W-1:0]        out_src,
  output logic                    abort
);

  logic             state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [7:0]       beat_q, beat_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;

  logic [N_REQ-1:0] pick;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic             hs, cur_req, cur_last, release_now;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign hs       = valid_q & out_ready;
  assign cur_req  = |(req & gnt_q);
  assign cur_last = |(last & gnt_q);
  // A word presented while reset is asserted is never acknowledged.
  assign ack      = (rst_n & hs) ? gnt_q : '0;
  assign out_data = wdata[int'(src_q)*DATA_W +: DATA_W];

  assign gnt       = gnt_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;
  assign abort     = abort_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    src_d       = src_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    valid_d     = valid_q;
    abort_d     = 1'b0;
    release_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          src_d   = pick_idx;
          beat_d  = '0;
          valid_d = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs) begin
          beat_d = (beat_q == 8'(MAX_BEATS)) ? beat_q : beat_q + 8'd1;
          // A word accepted as req drops is treated as the burst's final word.
          release_now = cur_last | ~cur_req | (beat_q + 8'd1 == 8'(MAX_BEATS));
        end else if (!cur_req) begin
          release_now = 1'b1;
          abort_d     = 1'b1;
        end
        if (release_now) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          src_d   = '0;
          valid_d = 1'b0;
          ptr_d   = src_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      ptr_q   <= SRC_W'(N_REQ - 1);
      beat_q  <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Randomized bench: burst-generating requester agents plus a transaction-level
// ownership model predicting grants, acks, data, aborts and forced releases.
module tb_io_arbiter;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, last, gnt, ack;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, abort;
  logic [2:0]      out_src;

  int n_cmp = 0;
  int n_err = 0;

  // Agent state: remaining words in the current burst and word sequence number.
  int rem [N];
  int seq [N];
  // Model state: current owner (-1 = nobody), last winner, beats this grant.
  int  owner, ptr, beats;
  bit  m_abort;

  io_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .last(last),
    .gnt(gnt), .ack(ack), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src(out_src), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return {4'(i), 12'(seq[i])};
  endfunction

  task automatic drive_agents();
    for (int i = 0; i < N; i++) begin
      req[i]            = (rem[i] > 0);
      last[i]           = (rem[i] == 1);
      wdata[i*DW +: DW] = word_of(i);
    end
  endtask

  initial begin
    bit do_rst, rdy;
    int o;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    owner = -1; ptr = N - 1; beats = 0; m_abort = 0;
    rst_n = 1'b0; out_ready = 1'b0;
    drive_agents();
    repeat (3) @(posedge clk);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      do_rst = (cyc > 10) && ($urandom_range(0, 249) == 0);
      for (int i = 0; i < N; i++)
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 12);
      rdy = ($urandom_range(0, 99) < 70);
      // Occasionally the owner gives up mid-burst while the channel is stalled.
      if (owner >= 0 && !rdy && $urandom_range(0, 9) == 0) rem[owner] = 0;
      rst_n = ~do_rst;
      out_ready = rdy;
      drive_agents();
      #1;

      chk("gnt", 32'(gnt), (owner >= 0) ? (32'd1 << owner) : 32'd0);
      chk("out_valid", 32'(out_valid), 32'(owner >= 0));
      chk("out_src", 32'(out_src), (owner >= 0) ? 32'(owner) : 32'd0);
      chk("abort", 32'(abort), 32'(m_abort));
      chk("ack", 32'(ack), (owner >= 0 && rdy && !do_rst) ? (32'd1 << owner) : 32'd0);
      if (owner >= 0) chk("out_data", 32'(out_data), 32'(word_of(owner)));

      m_abort = 0;
      if (do_rst) begin
        owner = -1;
        ptr   = N - 1;
      end else if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (owner < 0 && rem[(ptr + k) % N] > 0) begin
            owner = (ptr + k) % N;
            beats = 0;
          end
        end
      end else if (rdy) begin
        o = owner;
        beats++;
        rem[o]--;
        seq[o]++;
        if (rem[o] == 0 || beats == MB) begin
          ptr   = o;
          owner = -1;
        end
      end else if (rem[owner] == 0) begin
        m_abort = 1;
        ptr     = owner;
        owner   = -1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
